// File: rtl/pos_sweep_controller.sv
// Self-test sequencer for a 3-input POS gate: sweeps x,y,z over 000..111, samples F/Fn
// after a settle time and scores each vector against a golden truth table.
module pos_sweep_controller #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'h3A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f_in,
  input  logic       fn_in,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] captured,
  output logic [7:0] fail_vec
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned ERR_W = 4;
  localparam int unsigned NVEC  = 8;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(NVEC);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NVEC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       cap_q, cap_d;
  logic [7:0]       fail_q, fail_d;
  logic             vec_fail;

  // A vector fails on a wrong F or on a complementary output that is not ~F.
  assign vec_fail = (f_in != EXPECTED[idx_q]) || (fn_in != ~f_in);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    cap_d   = cap_q;
    fail_d  = fail_q;

    case (state_q)
      S_IDLE: begin
        vec_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_APPLY;
          idx_d   = '0;
          vec_d   = '0;
          busy_d  = 1'b1;
          err_d   = '0;
          cap_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end

      S_APPLY: begin
        cnt_d   = SETTLE_LOAD;
        state_d = (SETTLE_LOAD == '0) ? S_SAMPLE : S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        cap_d[idx_q] = f_in;
        if (vec_fail) begin
          fail_d[idx_q] = 1'b1;
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
        end else begin
          // Stimulus only moves on entry to APPLY, so it is steady for the whole vector.
          idx_d   = idx_q + IDX_W'(1);
          vec_d   = idx_q + IDX_W'(1);
          state_d = S_APPLY;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      cap_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
      fail_q  <= fail_d;
    end
  end

  assign {x, y, z}  = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign captured   = cap_q;
  assign fail_vec   = fail_q;

endmodule

// File: tb/tb_pos_sweep_controller.sv
// Bench for pos_sweep_controller: a settle-2 and a settle-0 instance driven by a
// behavioural gate model with selectable faults, scored against a truth-table model.
module tb_pos_sweep_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_drv = 1'b0;
  logic sel = 1'b0;
  int   mode = 0;
  logic [7:0] rf = 8'h00;
  logic [7:0] rfn = 8'h00;

  logic start0, start1;
  logic f0, fn0, f1, fn1;
  logic x0, y0, z0, busy0, done0, pass0;
  logic x1, y1, z1, busy1, done1, pass1;
  logic [3:0] err0, err1;
  logic [7:0] cap0, cap1, fv0, fv1;

  logic [2:0] o_xyz;
  logic       o_busy, o_done, o_pass;
  logic [3:0] o_err;
  logic [7:0] o_cap, o_fv;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign start0 = start_drv & ~sel;
  assign start1 = start_drv & sel;

  pos_sweep_controller #(.SETTLE_CYCLES(2), .EXPECTED(8'h3A)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .f_in(f0), .fn_in(fn0),
    .x(x0), .y(y0), .z(z0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .captured(cap0), .fail_vec(fv0)
  );

  pos_sweep_controller #(.SETTLE_CYCLES(0), .EXPECTED(8'h3A)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f1), .fn_in(fn1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .captured(cap1), .fail_vec(fv1)
  );

  // Intended gate function: F = (x|z) & (~x|~y).
  function automatic logic gold(input logic [2:0] v);
    return (v[2] | v[0]) & (~v[2] | ~v[1]);
  endfunction

  function automatic logic gate_f(input int m, input logic [2:0] v, input logic [7:0] tf);
    case (m)
      0, 2:    return gold(v);
      1:       return 1'b0;
      default: return tf[v];
    endcase
  endfunction

  function automatic logic gate_fn(input int m, input logic [2:0] v, input logic [7:0] tf,
                                   input logic [7:0] tfn);
    case (m)
      0:       return ~gold(v);
      1:       return 1'b1;
      2:       return gold(v);
      default: return tfn[v];
    endcase
  endfunction

  always_comb begin
    f0  = gate_f(mode, {x0, y0, z0}, rf);
    fn0 = gate_fn(mode, {x0, y0, z0}, rf, rfn);
    f1  = gate_f(mode, {x1, y1, z1}, rf);
    fn1 = gate_fn(mode, {x1, y1, z1}, rf, rfn);
  end

  always_comb begin
    o_xyz  = sel ? {x1, y1, z1} : {x0, y0, z0};
    o_busy = sel ? busy1 : busy0;
    o_done = sel ? done1 : done0;
    o_pass = sel ? pass1 : pass0;
    o_err  = sel ? err1 : err0;
    o_cap  = sel ? cap1 : cap0;
    o_fv   = sel ? fv1 : fv0;
  end

  // Expected sweep result from the truth-table rules.
  task automatic model(input int m, output logic [7:0] cap, output logic [7:0] fl,
                       output int errs);
    logic f, fn;
    cap = '0; fl = '0; errs = 0;
    for (int v = 0; v < 8; v++) begin
      f  = gate_f(m, 3'(v), rf);
      fn = gate_fn(m, 3'(v), rf, rfn);
      cap[v] = f;
      if (f != gold(3'(v)) || fn == f) begin
        fl[v] = 1'b1;
        errs++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sweep on the selected instance; poke pulses start while busy.
  task automatic sweep(input logic s, input bit poke, input string name);
    int per, n, bad, errs;
    logic [7:0] ecap, efl;
    per = s ? 2 : 4;
    n   = 8 * per;
    sel = s;
    model(mode, ecap, efl, errs);
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    bad = 0;
    for (int j = 0; j < n; j++) begin
      if (o_xyz !== 3'(j / per) || o_busy !== 1'b1 || o_done !== 1'b0) bad++;
      start_drv = (poke && (j % 5 == 2)) ? 1'b1 : 1'b0;
      tick();
    end
    start_drv = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_stepping: %0d bad cycles, required 0", name, bad);
    end
    n_checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_timing: done=%b busy=%b at cycle %0d, required done=1 busy=0",
               name, o_done, o_busy, n);
    end
    n_checks++;
    if (o_cap !== ecap || o_fv !== efl || o_err !== 4'(errs) || o_pass !== (errs == 0)) begin
      n_fail++;
      $display("FAIL %s_result: cap=%h fv=%h err=%0d pass=%b, required cap=%h fv=%h err=%0d pass=%b",
               name, o_cap, o_fv, o_err, o_pass, ecap, efl, errs, (errs == 0));
    end
    tick();
    tick();
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_cap !== ecap || o_fv !== efl ||
        o_pass !== (errs == 0)) begin
      n_fail++;
      $display("FAIL %s_hold: done=%b busy=%b cap=%h fv=%h pass=%b, required 0 0 %h %h %b",
               name, o_done, o_busy, o_cap, o_fv, o_pass, ecap, efl, (errs == 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({x0, y0, z0, busy0, done0, pass0, err0, cap0, fv0} !== 25'd0 ||
        {x1, y1, z1, busy1, done1, pass1, err1, cap1, fv1} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_state: dut0=%h dut1=%h, required 0",
               {x0, y0, z0, busy0, done0, pass0, err0, cap0, fv0},
               {x1, y1, z1, busy1, done1, pass1, err1, cap1, fv1});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fault_modes();
    mode = 0; sweep(1'b0, 1'b0, "gate_ok");
    mode = 1; sweep(1'b0, 1'b0, "stuck_f0");
    mode = 2; sweep(1'b0, 1'b0, "fn_eq_f");
    mode = 0;
  endtask

  task automatic test_mid_sweep_reset();
    sel = 1'b0;
    mode = 2;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int j = 0; j < 13; j++) tick();
    n_checks++;
    if (o_xyz !== 3'd3 || o_fv !== 8'h07 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: xyz=%0d fv=%h busy=%b, required 3 07 1", o_xyz, o_fv, o_busy);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (o_xyz !== 3'd0 || o_busy !== 1'b0 || o_err !== 4'd0 || o_fv !== 8'h00 ||
        o_cap !== 8'h00 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: xyz=%0d busy=%b err=%0d fv=%h cap=%h done=%b, required all 0",
               o_xyz, o_busy, o_err, o_fv, o_cap, o_done);
    end
    rst = 1'b0;
    mode = 0;
    tick();
    sweep(1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_rst_with_start();
    sel = 1'b0;
    rst = 1'b1;
    start_drv = 1'b1;
    tick();
    rst = 1'b0;
    start_drv = 1'b0;
    tick();
    n_checks++;
    if (o_busy !== 1'b0 || o_xyz !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_start: busy=%b xyz=%0d, required 0 0", o_busy, o_xyz);
    end
  endtask

  task automatic test_start_during_busy();
    mode = 0;
    sweep(1'b0, 1'b1, "poke_busy");
  endtask

  task automatic test_back_to_back();
    int bad;
    sel = 1'b0;
    mode = 0;
    start_drv = 1'b1;
    tick();
    for (int j = 0; j < 32; j++) tick();
    n_checks++;
    if (o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_done: done=%b, required 1", o_done);
    end
    tick();
    n_checks++;
    if (o_pass !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: pass=%b busy=%b, required 1 0", o_pass, o_busy);
    end
    tick();
    start_drv = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_pass !== 1'b0 || o_xyz !== 3'd0 || o_cap !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_relaunch: busy=%b pass=%b xyz=%0d cap=%h, required 1 0 0 00",
               o_busy, o_pass, o_xyz, o_cap);
    end
    bad = 0;
    for (int j = 1; j < 32; j++) begin
      tick();
      if (o_done !== 1'b0) bad++;
    end
    tick();
    n_checks++;
    if (bad != 0 || o_done !== 1'b1 || o_cap !== 8'h3A || o_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_done: early=%0d done=%b cap=%h pass=%b, required 0 1 3a 1",
               bad, o_done, o_cap, o_pass);
    end
    tick();
  endtask

  task automatic test_settle_zero();
    mode = 0;
    sweep(1'b1, 1'b0, "settle0");
    mode = 1;
    sweep(1'b1, 1'b0, "settle0_stuck");
    mode = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      rf  = 8'($urandom);
      rfn = (it % 3 == 0) ? ~rf : 8'($urandom);
      mode = 3;
      sweep(1'(it % 2), 1'b0, $sformatf("random%0d", it));
    end
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_fault_modes();
    test_mid_sweep_reset();
    test_rst_with_start();
    test_start_during_busy();
    test_back_to_back();
    test_settle_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
